// File: rtl/writeback_arbiter.sv
// Merges the fixed-latency ALU result stream and a 2-entry buffered divider
// stream onto one writeback port. The ALU path always wins; buffered results
// age out through a starvation counter that requests an ALU issue stall.
module writeback_arbiter #(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_alu_valid,
  input  logic [6:0]  io_alu_bits_rob_idx,
  input  logic [6:0]  io_alu_bits_pdst,
  input  logic [1:0]  io_alu_bits_dst_rtype,
  input  logic [63:0] io_alu_bits_data,
  input  logic        io_div_valid,
  output logic        io_div_ready,
  input  logic [6:0]  io_div_bits_rob_idx,
  input  logic [6:0]  io_div_bits_pdst,
  input  logic [1:0]  io_div_bits_dst_rtype,
  input  logic [19:0] io_div_bits_br_mask,
  input  logic [63:0] io_div_bits_data,
  input  logic [19:0] io_brupdate_b1_resolve_mask,
  input  logic [19:0] io_brupdate_b1_mispredict_mask,
  input  logic        io_flush,
  output logic        io_wb_valid,
  output logic [6:0]  io_wb_bits_rob_idx,
  output logic [6:0]  io_wb_bits_pdst,
  output logic [1:0]  io_wb_bits_dst_rtype,
  output logic [64:0] io_wb_bits_data,
  output logic        io_alu_block,
  output logic [1:0]  io_buf_count
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef struct packed {
    logic        valid;
    logic [6:0]  rob_idx;
    logic [6:0]  pdst;
    logic [1:0]  dst_rtype;
    logic [19:0] br_mask;
    logic [63:0] data;
  } slot_t;

  // slots[0] is always the oldest entry; slots[1] is valid only if slots[0] is.
  slot_t      slots [2];
  slot_t      nxt   [2];
  slot_t      upd   [2];
  slot_t      new_entry;
  logic [1:0] kill;
  logic       head_sel;
  logic       enq;
  logic       surv0;
  logic       surv1;
  logic [3:0] starve;
  logic [3:0] starve_nxt;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      kill[i]        = io_flush | (|(slots[i].br_mask & io_brupdate_b1_mispredict_mask));
      upd[i]         = slots[i];
      upd[i].br_mask = slots[i].br_mask & ~io_brupdate_b1_resolve_mask;
    end
  end

  assign io_buf_count = 2'(slots[0].valid) + 2'(slots[1].valid);
  assign io_div_ready = (io_buf_count < 2'd2);
  assign head_sel     = ~io_alu_valid & slots[0].valid & ~kill[0];
  assign enq          = io_div_valid & io_div_ready & ~io_flush
                      & ((io_div_bits_br_mask & io_brupdate_b1_mispredict_mask) == 20'd0);

  assign new_entry = '{valid:     1'b1,
                       rob_idx:   io_div_bits_rob_idx,
                       pdst:      io_div_bits_pdst,
                       dst_rtype: io_div_bits_dst_rtype,
                       br_mask:   io_div_bits_br_mask & ~io_brupdate_b1_resolve_mask,
                       data:      io_div_bits_data};

  assign io_wb_valid          = io_alu_valid | head_sel;
  assign io_wb_bits_rob_idx   = io_alu_valid ? io_alu_bits_rob_idx   : slots[0].rob_idx;
  assign io_wb_bits_pdst      = io_alu_valid ? io_alu_bits_pdst      : slots[0].pdst;
  assign io_wb_bits_dst_rtype = io_alu_valid ? io_alu_bits_dst_rtype : slots[0].dst_rtype;
  assign io_wb_bits_data      = {1'b0, io_alu_valid ? io_alu_bits_data : slots[0].data};

  assign surv0 = slots[0].valid & ~kill[0] & ~head_sel;
  assign surv1 = slots[1].valid & ~kill[1];

  // Survivors compact toward slot 0 in age order, then the new entry lands behind them.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    nxt[0] = '0;
    nxt[1] = '0;
    if (surv0) begin
      nxt[0] = upd[0];
      if (surv1)    nxt[1] = upd[1];
      else if (enq) nxt[1] = new_entry;
    end else if (surv1) begin
      nxt[0] = upd[1];
      if (enq) nxt[1] = new_entry;
    end else if (enq) begin
      nxt[0] = new_entry;
    end
  end

  always_comb begin
    starve_nxt = starve;
    if (io_flush | head_sel | ~nxt[0].valid)
      starve_nxt = 4'd0;
    else if (slots[0].valid & ~kill[0] & io_alu_valid & (starve < LIMIT))
      starve_nxt = starve + 4'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: only the valid bits need reset; payload fields are ignored while their slot is invalid.
      slots[0].valid <= 1'b0;
      slots[1].valid <= 1'b0;
      starve         <= 4'd0;
      io_alu_block   <= 1'b0;
    end else begin
      slots[0]     <= nxt[0];
      slots[1]     <= nxt[1];
      starve       <= starve_nxt;
      io_alu_block <= (starve >= LIMIT);
    end
  end

endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 8, cycles a buffered divider result may wait before ALU issue is blocked (range 2..15).
REQ-002 SHALL have port clock, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous and active-high.
REQ-004 SHALL have port io_alu_valid, input, 1, fixed-latency ALU result present this cycle; it cannot be stalled.
REQ-005 SHALL have port io_alu_bits_{rob_idx 7, pdst 7, dst_rtype 2, data 64}, input, ALU result fields.
REQ-006 SHALL have port io_div_valid, input, 1, divider result offered.
REQ-007 SHALL have port io_div_ready, output, 1, buffer can accept a divider result.
REQ-008 SHALL have port io_div_bits_{rob_idx 7, pdst 7, dst_rtype 2, br_mask 20, data 64}, input, divider result fields.
REQ-009 SHALL have ports io_brupdate_b1_resolve_mask and io_brupdate_b1_mispredict_mask, input, 20 each, branch resolution this cycle.
REQ-010 SHALL have port io_flush, input, 1, pipeline flush.
REQ-011 SHALL have port io_wb_valid, output, 1, shared writeback port valid.
REQ-012 SHALL have port io_wb_bits_{rob_idx 7, pdst 7, dst_rtype 2}, output, writeback fields.
REQ-013 SHALL have port io_wb_bits_data, output, 65, {1'b0, selected 64-bit data}.
REQ-014 SHALL have port io_alu_block, output, 1, registered request that the scheduler not issue ALU ops.
REQ-015 SHALL have port io_buf_count, output, 2, valid buffer entries (0..2).

Function
REQ-016 SHALL hold a 2-slot age-ordered buffer; each slot holds valid, rob_idx, pdst, dst_rtype, br_mask, data.
REQ-017 io_div_ready SHALL equal (io_buf_count < 2), from registered state only; a dequeue in the same cycle does not free a slot for that cycle.
REQ-018 Enqueue SHALL occur when io_div_valid & io_div_ready & ~io_flush & ((io_div_bits_br_mask & mispredict_mask) == 0); stored br_mask = br_mask & ~resolve_mask. A handshaked but killed result is silently dropped.
REQ-019 Each cycle every valid slot SHALL update br_mask &= ~resolve_mask; a slot with (br_mask & mispredict_mask) != 0 is invalidated at the clock edge; the surviving slot keeps its age order.
REQ-020 Writeback SHALL be combinational: io_alu_valid=1 selects ALU fields; otherwise the oldest valid slot is selected if it is not killed this cycle (mispredict hit or io_flush).
REQ-021 A slot selected for writeback SHALL be dequeued at that edge; a killed head SHALL NOT be written back and the younger slot is not promoted in the same cycle.
REQ-022 io_wb_valid SHALL be io_alu_valid | (buffer head selected); when 0, wb fields are don't-care but data bit 64 is always 0.
REQ-023 Minimum divider latency through the block SHALL be 1 cycle (accept at t, writeback at t+1 earliest).
REQ-024 io_flush SHALL invalidate all slots at the edge and suppress buffer writeback that cycle; the ALU path is unaffected.
REQ-025 A starve counter (4-bit) SHALL increment, saturating at STARVE_LIMIT, each cycle a valid unkilled head exists and io_alu_valid=1; it SHALL clear when a slot is written back, the buffer empties, or io_flush.
REQ-026 io_alu_block SHALL be registered, 1 in the cycle after counter >= STARVE_LIMIT, and drop the cycle after the counter clears.
REQ-027 Simultaneous enqueue and dequeue with count=1 SHALL leave count=1, the new entry becoming the sole (oldest) slot.

Reset
REQ-028 While reset=1 at an edge, all slots SHALL be invalid, starve counter 0, io_alu_block 0.
REQ-029 After reset, io_div_ready=1, io_buf_count=0, io_wb_valid=io_alu_valid.

Verification
REQ-030 Div result rob_idx=5 accepted at t with ALU idle -> io_wb_valid=1, rob_idx=5 at t+1; io_buf_count returns to 0.
REQ-031 ALU valid every cycle, two div results accepted -> io_div_ready=0, count=2; io_alu_block=1 after STARVE_LIMIT+1 cycles; ALU drop -> oldest then younger written back in order.
REQ-032 Buffered slots with br_mask 0x00004 and 0x00008, mispredict_mask=0x00004 -> first dropped without writeback, second written back next idle cycle.
REQ-033 resolve_mask=0x00004 then mispredict_mask=0x00004 on a slot with br_mask 0x00004 -> slot survives and writes back.
REQ-034 io_flush with count=2 and ALU idle -> io_wb_valid=0 that cycle, count=0 next; reset asserted mid-operation -> same, io_alu_block=0.
